// File: rtl/dog_window_feeder.sv
// Streaming 3x3 neighbourhood generator for one DoG scale image.
// Two line buffers feed a 3x3 shift window; windows centred on interior pixels appear two cycles after their enabling pixel.
module dog_window_feeder #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic            iclk,
    input  logic            irst_n,
    input  logic [DW-1:0]   iData,
    input  logic            iValid,
    input  logic            iSof,
    output logic [3*DW-1:0] oWin_top,
    output logic [3*DW-1:0] oWin_mid,
    output logic [3*DW-1:0] oWin_bot,
    output logic [DW-1:0]   oCenter,
    output logic [15:0]     oPos_x,
    output logic [15:0]     oPos_y,
    output logic            oValid
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, curCol;
    logic [RW-1:0] row, curRow;

    logic [DW-1:0] lineBuf0 [IMG_W];
    logic [DW-1:0] lineBuf1 [IMG_W];
    logic [DW-1:0] lb0Rd, lb1Rd;

    logic [3*DW-1:0] winTop, winMid, winBot;
    logic            valid1;
    logic [15:0]     posX1, posY1;
    logic            emit;

    // An accepted start-of-frame pixel is (0,0) whatever the counters say.
    always_comb begin
        curCol = iSof ? '0 : col;
        curRow = iSof ? '0 : row;
        lb0Rd  = lineBuf0[curCol];
        lb1Rd  = lineBuf1[curCol];
        emit   = iValid && (curRow >= RW'(2)) && (curCol >= CW'(2));
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            col <= '0;
            row <= '0;
        end else if (iValid) begin
            if (curCol == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (curRow == RW'(IMG_H - 1)) ? '0 : curRow + RW'(1);
            end else begin
                col <= curCol + CW'(1);
                row <= curRow;
            end
        end
    end

    // Line buffers are not reset; both rows are rewritten before any window uses them.
    always_ff @(posedge iclk) begin
        if (iValid) begin
            lineBuf0[curCol] <= lb1Rd;
            lineBuf1[curCol] <= iData;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            winTop <= '0;
            winMid <= '0;
            winBot <= '0;
            valid1 <= 1'b0;
            posX1  <= '0;
            posY1  <= '0;
        end else begin
            valid1 <= emit;
            if (iValid) begin
                winTop <= {lb0Rd, winTop[3*DW-1:DW]};
                winMid <= {lb1Rd, winMid[3*DW-1:DW]};
                winBot <= {iData, winBot[3*DW-1:DW]};
                posX1  <= 16'(curCol) - 16'd1;
                posY1  <= 16'(curRow) - 16'd1;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oWin_top <= '0;
            oWin_mid <= '0;
            oWin_bot <= '0;
            oPos_x   <= '0;
            oPos_y   <= '0;
            oValid   <= 1'b0;
        end else begin
            oValid <= valid1;
            if (valid1) begin
                oWin_top <= winTop;
                oWin_mid <= winMid;
                oWin_bot <= winBot;
                oPos_x   <= posX1;
                oPos_y   <= posY1;
            end
        end
    end

    assign oCenter = oWin_mid[2*DW-1:DW];

endmodule

// File: tb/tb_dog_window_feeder.sv
// Bench for dog_window_feeder on a 5x4 image: a frame-array model predicts every window and its arrival cycle.
module tb_dog_window_feeder;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic [DW-1:0] iData = '0;
    logic          iValid = 1'b0;
    logic          iSof = 1'b0;
    logic [3*DW-1:0] oWin_top, oWin_mid, oWin_bot;
    logic [DW-1:0]   oCenter;
    logic [15:0]     oPos_x, oPos_y;
    logic            oValid;

    dog_window_feeder #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .iclk(iclk), .irst_n(irst_n), .iData(iData), .iValid(iValid), .iSof(iSof),
        .oWin_top(oWin_top), .oWin_mid(oWin_mid), .oWin_bot(oWin_bot),
        .oCenter(oCenter), .oPos_x(oPos_x), .oPos_y(oPos_y), .oValid(oValid)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] top;
        logic [23:0] mid;
        logic [23:0] bot;
        logic [7:0]  ctr;
        logic [15:0] px;
        logic [15:0] py;
    } win_t;

    win_t expQ[$];
    win_t obsQ[$];
    int   cyc = 0;
    int   k = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] img [H][W];

    // One clock of stimulus; the model places the pixel in the frame and predicts its window.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        win_t e;
        logic emit;
        int r, c;
        emit = 1'b0;
        e = '0;
        iValid = v; iSof = s; iData = d;
        if (v) begin
            if (s) k = 0;
            r = k / W;
            c = k % W;
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                emit  = 1'b1;
                e.top = {img[r-2][c], img[r-2][c-1], img[r-2][c-2]};
                e.mid = {img[r-1][c], img[r-1][c-1], img[r-1][c-2]};
                e.bot = {img[r][c],   img[r][c-1],   img[r][c-2]};
                e.ctr = img[r-1][c-1];
                e.px  = 16'(c - 1);
                e.py  = 16'(r - 1);
            end
            k = (k + 1) % (W * H);
        end
        @(posedge iclk);
        cyc++;
        if (emit) begin
            e.cyc = 32'(cyc + 1);
            expQ.push_back(e);
        end
        @(negedge iclk);
        if (oValid) begin
            e.cyc = 32'(cyc);
            e.top = oWin_top; e.mid = oWin_mid; e.bot = oWin_bot;
            e.ctr = oCenter;  e.px  = oPos_x;   e.py  = oPos_y;
            obsQ.push_back(e);
        end
        iValid = 1'b0;
        iSof = 1'b0;
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        if (mode == 0) return 8'(16 * r + c);
        if (mode == 1) return 8'(255 - (16 * r + c));
        return 8'($urandom_range(0, 255));
    endfunction

    // gapMode: 0 continuous, 1 valid pattern 1,0,0, 2 random gaps
    task automatic drive_frame(input int mode, input int gapMode);
        for (int i = 0; i < W * H; i++) begin
            if (gapMode == 1 && i > 0) begin
                step(1'b0, 1'b0, 8'h5A);
                step(1'b0, 1'b1, 8'hA5);
            end
            if (gapMode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 8'h3C);
            step(1'b1, (i == 0), pix(mode, i / W, i % W));
        end
    endtask

    task automatic flush();
        repeat (4) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_queues();
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_reset();
        irst_n = 1'b0;
        #3;
        vectors++;
        if ({oWin_top, oWin_mid, oWin_bot, oCenter, oPos_x, oPos_y, oValid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h %h %h %h %h %h %b required all zero",
                     oWin_top, oWin_mid, oWin_bot, oCenter, oPos_x, oPos_y, oValid);
        end
        @(negedge iclk);
        irst_n = 1'b1;
        k = 0;
        @(negedge iclk);
    endtask

    task automatic test_basic();
        clear_queues();
        drive_frame(0, 0);
        flush();
        vectors++;
        if (obsQ.size() != 6) begin
            miscompares++;
            $display("FAIL basic_count got %0d required 6", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL basic_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
        if (obsQ.size() == 6) begin
            vectors++;
            if ({obsQ[0].top, obsQ[0].mid, obsQ[0].bot, obsQ[0].ctr, obsQ[0].px, obsQ[0].py} !==
                {24'h020100, 24'h121110, 24'h222120, 8'h11, 16'd1, 16'd1}) begin
                miscompares++;
                $display("FAIL basic_first got %h required 020100_121110_222120_11_1_1", obsQ[0]);
            end
            vectors++;
            if ({obsQ[5].ctr, obsQ[5].px, obsQ[5].py} !== {8'h23, 16'd3, 16'd2}) begin
                miscompares++;
                $display("FAIL basic_last got ctr=%h x=%0d y=%0d required ctr=23 x=3 y=2",
                         obsQ[5].ctr, obsQ[5].px, obsQ[5].py);
            end
        end
    endtask

    task automatic test_gaps();
        clear_queues();
        drive_frame(0, 1);
        flush();
        vectors++;
        if (obsQ.size() != expQ.size() || obsQ.size() != 6) begin
            miscompares++;
            $display("FAIL gaps_count got %0d required 6", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL gaps_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        drive_frame(0, 0);
        drive_frame(1, 0);
        flush();
        vectors++;
        if (obsQ.size() != 12) begin
            miscompares++;
            $display("FAIL b2b_count got %0d required 12", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL b2b_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_resync();
        clear_queues();
        for (int i = 0; i <= 12; i++) step(1'b1, (i == 0), pix(0, i / W, i % W));
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        drive_frame(2, 0);
        flush();
        vectors++;
        if (obsQ.size() != 7) begin
            miscompares++;
            $display("FAIL resync_count got %0d required 7", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL resync_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_queues();
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0), pix(2, i / W, i % W));
        #2;
        irst_n = 1'b0;
        #1;
        vectors++;
        if ({oWin_top, oWin_mid, oWin_bot, oCenter, oPos_x, oPos_y, oValid} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got %h %h %h %h %h %h %b required all zero",
                     oWin_top, oWin_mid, oWin_bot, oCenter, oPos_x, oPos_y, oValid);
        end
        @(negedge iclk);
        irst_n = 1'b1;
        k = 0;
        @(negedge iclk);
        clear_queues();
        drive_frame(2, 0);
        flush();
        vectors++;
        if (obsQ.size() != 6) begin
            miscompares++;
            $display("FAIL midreset_count got %0d required 6", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL midreset_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_row_wrap();
        clear_queues();
        drive_frame(2, 2);
        flush();
        vectors++;
        if (obsQ.size() != 6) begin
            miscompares++;
            $display("FAIL wrap_count got %0d required 6", obsQ.size());
        end
        for (int i = 0; i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i].px !== 16'(i % 3 + 1) || obsQ[i].py !== 16'(i / 3 + 1)) begin
                miscompares++;
                $display("FAIL wrap_pos[%0d] got (%0d,%0d) required (%0d,%0d)",
                         i, obsQ[i].px, obsQ[i].py, i % 3 + 1, i / 3 + 1);
            end
        end
    endtask

    task automatic test_random();
        clear_queues();
        repeat (3) drive_frame(2, 2);
        flush();
        vectors++;
        if (obsQ.size() != 18) begin
            miscompares++;
            $display("FAIL random_count got %0d required 18", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            vectors++;
            if (obsQ[i] !== expQ[i]) begin
                miscompares++;
                $display("FAIL random_win[%0d] got %h required %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    initial begin
        @(negedge iclk);
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_reset();
        test_reset_midframe();
        test_row_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
